// File: rtl/dmem_responder_if.sv
// Request/response bus between the hart's memory stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic        i_req_ren;
  logic        i_req_wen;
  logic [31:0] i_req_wdata;
  logic [3:0]  i_req_mask;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  modport master (
    output i_req_valid, i_req_addr, i_req_ren, i_req_wen, i_req_wdata, i_req_mask,
    output i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_addr, i_req_ren, i_req_wen, i_req_wdata, i_req_mask,
    input  i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Latency-bearing data-memory responder, one request outstanding.
// Define DMEM_RESPONDER_RANDOM_STALL_EN to add 0..3 LFSR-driven extra latency cycles.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_W32 = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [4:0]  cnt_r;
  logic [4:0]  cnt_nxt_s;
  logic [4:0]  load_s;

  logic [31:0] req_addr_r;
  logic        req_ren_r;
  logic        req_wen_r;
  logic [31:0] req_wdata_r;
  logic [3:0]  req_mask_r;

  logic [31:0] cur_addr_s;
  logic        cur_ren_s;
  logic        cur_wen_s;
  logic [31:0] cur_wdata_s;
  logic [3:0]  cur_mask_s;
  logic [31:0] idx_full_s;
  logic [IDX_W-1:0] cur_idx_s;
  logic        cur_err_s;
  logic        accept_s;
  logic        enter_resp_s;
  logic        mem_we_s;
  logic [31:0] rsp_rdata_s;

  logic        req_ready_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_rdata_r;
  logic        rsp_err_r;

  logic [31:0] mem_r [DEPTH_WORDS];

  function automatic logic [31:0] mask_expand(input logic [3:0] m);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = {8{m[b]}};
    end
    return r;
  endfunction

`ifdef DMEM_RESPONDER_RANDOM_STALL_EN
  logic [7:0] lfsr_r;

  // Free-running stall LFSR, x^8+x^6+x^5+x^4+1
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lfsr_r <= 8'hA5;
    end else begin
      lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
    end
  end

  assign load_s = 5'(LATENCY - 1) + {3'b000, lfsr_r[1:0]};
`else
  assign load_s = 5'(LATENCY - 1);
`endif

  assign accept_s = (state_r == ST_IDLE) && bus.i_req_valid;

  // In IDLE the request being entered into RESP (LATENCY=1) is still on the bus
  always_comb begin
    cur_addr_s  = req_addr_r;
    cur_ren_s   = req_ren_r;
    cur_wen_s   = req_wen_r;
    cur_wdata_s = req_wdata_r;
    cur_mask_s  = req_mask_r;
    if (state_r == ST_IDLE) begin
      cur_addr_s  = bus.i_req_addr;
      cur_ren_s   = bus.i_req_ren;
      cur_wen_s   = bus.i_req_wen;
      cur_wdata_s = bus.i_req_wdata;
      cur_mask_s  = bus.i_req_mask;
    end else begin
      cur_addr_s  = req_addr_r;
    end
  end

  // Fault detection; addresses below BASE_ADDR wrap to a huge index
  always_comb begin
    idx_full_s = (cur_addr_s - BASE_ADDR) >> 2;
    cur_idx_s  = idx_full_s[IDX_W-1:0];
    cur_err_s  = (cur_ren_s && cur_wen_s)
              || (cur_addr_s[1:0] != 2'b00)
              || ((cur_mask_s == 4'b0000) && (cur_ren_s || cur_wen_s))
              || (idx_full_s >= DEPTH_W32);
  end

  // Next-state and latency counter
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_req_valid) begin
          cnt_nxt_s   = load_s;
          state_nxt_s = (load_s == 5'd0) ? ST_RESP : ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_nxt_s = cnt_r - 5'd1;
        if (cnt_r == 5'd1) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (bus.i_rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 5'd0;
      end
    endcase
  end

  // Read data and write enable evaluated at the edge that enters RESP
  always_comb begin
    enter_resp_s = (state_nxt_s == ST_RESP) && (state_r != ST_RESP);
    mem_we_s     = i_rst_n && enter_resp_s && cur_wen_s && !cur_err_s;
    if (cur_ren_s && !cur_err_s) begin
      rsp_rdata_s = mem_r[cur_idx_s] & mask_expand(cur_mask_s);
    end else begin
      rsp_rdata_s = 32'h0;
    end
  end

  // FSM state and registered response outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 5'd0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      req_ready_r <= (state_nxt_s == ST_IDLE);
      rsp_valid_r <= (state_nxt_s == ST_RESP);
      if (enter_resp_s) begin
        rsp_rdata_r <= rsp_rdata_s;
        rsp_err_r   <= cur_err_s;
      end else if (state_nxt_s == ST_IDLE) begin
        rsp_rdata_r <= 32'h0;
        rsp_err_r   <= 1'b0;
      end
    end
  end

  // Capture the accepted request
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      req_addr_r  <= 32'h0;
      req_ren_r   <= 1'b0;
      req_wen_r   <= 1'b0;
      req_wdata_r <= 32'h0;
      req_mask_r  <= 4'h0;
    end else if (accept_s) begin
      req_addr_r  <= bus.i_req_addr;
      req_ren_r   <= bus.i_req_ren;
      req_wen_r   <= bus.i_req_wen;
      req_wdata_r <= bus.i_req_wdata;
      req_mask_r  <= bus.i_req_mask;
    end
  end

  // Byte-lane write port; the array itself is never reset
  always_ff @(posedge i_clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_mask_s[b]) begin
          mem_r[cur_idx_s][8*b +: 8] <= cur_wdata_s[8*b +: 8];
        end
      end
    end
  end

  assign bus.o_req_ready = req_ready_r;
  assign bus.o_rsp_valid = rsp_valid_r;
  assign bus.o_rsp_rdata = rsp_rdata_r;
  assign bus.o_rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected responses are queued at issue
// and popped when the responder answers.
module tb_dmem_responder;

  localparam int LAT = 2;
`ifdef DMEM_RESPONDER_RANDOM_STALL_EN
  localparam int LAT_MAX = LAT + 3;
`else
  localparam int LAT_MAX = LAT;
`endif

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        err;
    logic [31:0] rdata;
  } req_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  exp_t sb_q[$];

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .BASE_ADDR  (32'h0000_0000),
    .LATENCY    (LAT)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

  function automatic req_t mk(input logic [31:0] a, input logic r, input logic w,
                              input logic [31:0] d, input logic [3:0] m,
                              input logic e, input logic [31:0] rd);
    req_t q;
    q.addr = a; q.ren = r; q.wen = w; q.wdata = d; q.mask = m; q.err = e; q.rdata = rd;
    return q;
  endfunction

  task automatic send_req(input req_t r, input bit push, output bit ok);
    exp_t e;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.o_req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL req_ready_timeout got 0 want 1");
      return;
    end
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = r.addr;
    bus.i_req_ren   = r.ren;
    bus.i_req_wen   = r.wen;
    bus.i_req_wdata = r.wdata;
    bus.i_req_mask  = r.mask;
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
    bus.i_req_ren   = 1'b0;
    bus.i_req_wen   = 1'b0;
    if (push) begin
      e.err = r.err; e.rdata = r.rdata;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_rsp(input bit retire, output logic [31:0] rd, output logic er, output int lat);
    lat = -1; rd = 32'h0; er = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (bus.o_rsp_valid === 1'b1) begin
        lat = t;
        break;
      end
    end
    if (lat > 0) begin
      rd = bus.o_rsp_rdata;
      er = bus.o_rsp_err;
      if (retire) begin
        bus.i_rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.i_rsp_ready = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.i_req_valid = 1'b0; bus.i_req_addr = 32'h0; bus.i_req_ren = 1'b0;
    bus.i_req_wen = 1'b0; bus.i_req_wdata = 32'h0; bus.i_req_mask = 4'h0;
    bus.i_rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.o_req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b want 1", bus.o_req_ready); end
    n_cmp++; if (bus.o_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", bus.o_rsp_valid); end
    n_cmp++; if (bus.o_rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", bus.o_rsp_rdata); end
    n_cmp++; if (bus.o_rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", bus.o_rsp_err); end
  endtask

  task automatic test_word_rw;
    req_t q[$];
    logic [31:0] rd; logic er; int lat; bit ok; exp_t e;
    q.push_back(mk(32'h10,  1'b0, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0));
    q.push_back(mk(32'h10,  1'b1, 1'b0, 32'h0,        4'hF, 1'b0, 32'hDEADBEEF));
    q.push_back(mk(32'hFFC, 1'b0, 1'b1, 32'h0BADF00D, 4'hF, 1'b0, 32'h0));
    q.push_back(mk(32'hFFC, 1'b1, 1'b0, 32'h0,        4'hF, 1'b0, 32'h0BADF00D));
    q.push_back(mk(32'h0,   1'b0, 1'b0, 32'h12345678, 4'hF, 1'b0, 32'h0));
    foreach (q[i]) begin
      send_req(q[i], 1'b1, ok);
      if (ok) begin
        wait_rsp(1'b1, rd, er, lat);
        e = sb_q.pop_front();
        n_cmp++; if (lat < LAT || lat > LAT_MAX) begin n_bad++; $display("FAIL word_lat[%0d] got %0d want %0d..%0d", i, lat, LAT, LAT_MAX); end
        n_cmp++; if ({er, rd} !== {e.err, e.rdata}) begin n_bad++; $display("FAIL word_rsp[%0d] got err=%b rdata=%h want err=%b rdata=%h", i, er, rd, e.err, e.rdata); end
      end
    end
  endtask

  task automatic test_byte_write;
    req_t q[$];
    logic [31:0] rd; logic er; int lat; bit ok; exp_t e;
    q.push_back(mk(32'h10, 1'b0, 1'b1, 32'h00AA0000, 4'b0100, 1'b0, 32'h0));
    q.push_back(mk(32'h10, 1'b1, 1'b0, 32'h0,        4'hF,    1'b0, 32'hDEAABEEF));
    q.push_back(mk(32'h10, 1'b1, 1'b0, 32'h0,        4'b1100, 1'b0, 32'hDEAA0000));
    q.push_back(mk(32'h10, 1'b1, 1'b0, 32'h0,        4'b0001, 1'b0, 32'h000000EF));
    foreach (q[i]) begin
      send_req(q[i], 1'b1, ok);
      if (ok) begin
        wait_rsp(1'b1, rd, er, lat);
        e = sb_q.pop_front();
        n_cmp++; if (lat < LAT || lat > LAT_MAX) begin n_bad++; $display("FAIL byte_lat[%0d] got %0d want %0d..%0d", i, lat, LAT, LAT_MAX); end
        n_cmp++; if ({er, rd} !== {e.err, e.rdata}) begin n_bad++; $display("FAIL byte_rsp[%0d] got err=%b rdata=%h want err=%b rdata=%h", i, er, rd, e.err, e.rdata); end
      end
    end
  endtask

  task automatic test_errors;
    req_t q[$];
    logic [31:0] rd; logic er; int lat; bit ok; exp_t e;
    q.push_back(mk(32'h12,       1'b1, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0));
    q.push_back(mk(32'h10,       1'b1, 1'b1, 32'h11111111, 4'hF, 1'b1, 32'h0));
    q.push_back(mk(32'h1000,     1'b1, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0));
    q.push_back(mk(32'h1000,     1'b0, 1'b1, 32'h22222222, 4'hF, 1'b1, 32'h0));
    q.push_back(mk(32'h12,       1'b0, 1'b1, 32'h33333333, 4'hF, 1'b1, 32'h0));
    q.push_back(mk(32'h10,       1'b0, 1'b1, 32'h44444444, 4'h0, 1'b1, 32'h0));
    q.push_back(mk(32'hFFFFFFFC, 1'b1, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0));
    q.push_back(mk(32'h10,       1'b1, 1'b0, 32'h0,        4'hF, 1'b0, 32'hDEAABEEF));
    foreach (q[i]) begin
      send_req(q[i], 1'b1, ok);
      if (ok) begin
        wait_rsp(1'b1, rd, er, lat);
        e = sb_q.pop_front();
        n_cmp++; if (lat < LAT || lat > LAT_MAX) begin n_bad++; $display("FAIL err_lat[%0d] got %0d want %0d..%0d", i, lat, LAT, LAT_MAX); end
        n_cmp++; if ({er, rd} !== {e.err, e.rdata}) begin n_bad++; $display("FAIL err_rsp[%0d] got err=%b rdata=%h want err=%b rdata=%h", i, er, rd, e.err, e.rdata); end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd; logic er; int lat; bit ok; exp_t e;
    send_req(mk(32'h10, 1'b1, 1'b0, 32'h0, 4'hF, 1'b0, 32'hDEAABEEF), 1'b1, ok);
    if (ok) begin
      wait_rsp(1'b0, rd, er, lat);
      e = sb_q.pop_front();
      n_cmp++; if ({er, rd} !== {e.err, e.rdata}) begin n_bad++; $display("FAIL bp_rsp got err=%b rdata=%h want err=%b rdata=%h", er, rd, e.err, e.rdata); end
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        n_cmp++;
        if ({bus.o_rsp_valid, bus.o_req_ready, bus.o_rsp_err, bus.o_rsp_rdata} !== {1'b1, 1'b0, e.err, e.rdata}) begin
          n_bad++;
          $display("FAIL bp_hold[%0d] got valid=%b ready=%b err=%b rdata=%h want valid=1 ready=0 err=%b rdata=%h",
                   c, bus.o_rsp_valid, bus.o_req_ready, bus.o_rsp_err, bus.o_rsp_rdata, e.err, e.rdata);
        end
      end
      bus.i_rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.i_rsp_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if ({bus.o_req_ready, bus.o_rsp_valid} !== 2'b10) begin n_bad++; $display("FAIL bp_release got ready=%b valid=%b want ready=1 valid=0", bus.o_req_ready, bus.o_rsp_valid); end
    end
    send_req(mk(32'hFFC, 1'b1, 1'b0, 32'h0, 4'b0011, 1'b0, 32'h0000F00D), 1'b1, ok);
    if (ok) begin
      wait_rsp(1'b1, rd, er, lat);
      e = sb_q.pop_front();
      n_cmp++; if ({er, rd} !== {e.err, e.rdata}) begin n_bad++; $display("FAIL bp_next got err=%b rdata=%h want err=%b rdata=%h", er, rd, e.err, e.rdata); end
    end
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] rd; logic er; int lat; bit ok; exp_t e; int seen;
    send_req(mk(32'h20, 1'b0, 1'b1, 32'h11112222, 4'hF, 1'b0, 32'h0), 1'b1, ok);
    if (ok) begin
      wait_rsp(1'b1, rd, er, lat);
      e = sb_q.pop_front();
    end
    send_req(mk(32'h20, 1'b0, 1'b1, 32'h55555555, 4'hF, 1'b0, 32'h0), 1'b0, ok);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.o_rsp_valid !== 1'b0) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rst_wait_norsp got %0d valid cycles want 0", seen); end
    n_cmp++; if (bus.o_req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_wait_ready got %b want 1", bus.o_req_ready); end
    send_req(mk(32'h20, 1'b1, 1'b0, 32'h0, 4'hF, 1'b0, 32'h11112222), 1'b1, ok);
    if (ok) begin
      wait_rsp(1'b1, rd, er, lat);
      e = sb_q.pop_front();
      n_cmp++; if (lat < LAT || lat > LAT_MAX) begin n_bad++; $display("FAIL rst_wait_lat got %0d want %0d..%0d", lat, LAT, LAT_MAX); end
      n_cmp++; if ({er, rd} !== {e.err, e.rdata}) begin n_bad++; $display("FAIL rst_wait_read got err=%b rdata=%h want err=%b rdata=%h", er, rd, e.err, e.rdata); end
    end
  endtask

  task automatic test_random_stall;
    logic [31:0] rd; logic er; int lat; bit ok; exp_t e;
    int bad_lat;
    bad_lat = 0;
    for (int i = 0; i < 64; i++) begin
      if (i % 2 == 0) send_req(mk(32'h10, 1'b1, 1'b0, 32'h0, 4'hF, 1'b0, 32'hDEAABEEF), 1'b1, ok);
      else            send_req(mk(32'h20, 1'b1, 1'b0, 32'h0, 4'hF, 1'b0, 32'h11112222), 1'b1, ok);
      if (ok) begin
        wait_rsp(1'b1, rd, er, lat);
        e = sb_q.pop_front();
        if (lat < LAT || lat > LAT_MAX) bad_lat++;
        n_cmp++; if ({er, rd} !== {e.err, e.rdata}) begin n_bad++; $display("FAIL stall_rsp[%0d] got err=%b rdata=%h want err=%b rdata=%h", i, er, rd, e.err, e.rdata); end
      end
    end
    n_cmp++; if (bad_lat != 0) begin n_bad++; $display("FAIL stall_lat got %0d out-of-range want 0", bad_lat); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_word_rw();
    test_byte_write();
    test_errors();
    test_backpressure();
    test_reset_in_wait();
    test_random_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
